keypad3c4r_presser: RTL and testbench

- Synthesizable emulator of the 3-column x 4-row keypad matrix. It is the matrix side of the interface that the keypad scanner drives.
- Watches the scanner's one-hot row drive and returns column signals as if one requested key were physically held.
- Key requests arrive on a valid/ready handshake. Used for hardware self-test and for injecting keystrokes from other logic.

---
 rtl/keypad3c4r_presser_if.sv | 24 ++
 rtl/keypad3c4r_presser.sv | 163 ++++++++++++++++
 tb/tb_keypad3c4r_presser.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad3c4r_presser_if.sv
// Key request handshake and status bundle for keypad3c4r_presser.
// Handshake: a request transfers on a rising clk edge when key_valid && key_ready.
//   The requester holds key_valid/key_code stable until that edge.
//   The presser raises key_ready only while idle.
interface keypad3c4r_presser_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] pressed;
  logic [1:0]  state_dbg;

  modport master (
    output key_valid, key_code,
    input  key_ready, busy, done, err, pressed, state_dbg
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, busy, done, err, pressed, state_dbg
  );
endinterface

// File: rtl/keypad3c4r_presser.sv
// keypad3c4r_presser: emulates a 3-column x 4-row keypad matrix holding one
// requested key for HOLD_SCANS row scans, then releasing it for GAP_SCANS scans.
// Optional contact bounce: define KEYPAD3C4R_PRESSER_BOUNCE_EN.
module keypad3c4r_presser #(
  parameter logic [7:0]  HOLD_SCANS    = 8'd8,
  parameter logic [7:0]  GAP_SCANS     = 8'd8,
  parameter int unsigned BOUNCE_CYCLES = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  keypadr,
  output logic [2:0]                  keypadc,
  keypad3c4r_presser_if.slave         key_if
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // A zero scan count still produces one scan of press/release.
  localparam logic [7:0] HOLD_MAX = (HOLD_SCANS == 8'd0) ? 8'd1 : HOLD_SCANS;
  localparam logic [7:0] GAP_MAX  = (GAP_SCANS  == 8'd0) ? 8'd1 : GAP_SCANS;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [11:0] sel_mask, sel_nxt;
  logic [11:0] pressed, pressed_clean;
  logic        done_q, done_nxt;
  logic        err_q, err_nxt;
  logic        row3_q;
  logic        tick;
  logic        accept;

  // One scan completes each time the last row is newly driven.
  assign tick    = keypadr[3] & ~row3_q;
  assign accept  = key_if.key_valid && (state == IDLE);
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Next-state, scan counter and key selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_mask;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (key_if.key_code < 4'd12) begin
            state_nxt = PRESS;
            sel_nxt   = 12'd1 << key_if.key_code;
            cnt_nxt   = 8'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      PRESS: begin
        if (tick) begin
          if (cnt_inc >= HOLD_MAX) begin
            state_nxt = RELEASE;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      RELEASE: begin
        if (tick) begin
          if (cnt_inc >= GAP_MAX) begin
            state_nxt = IDLE;
            cnt_nxt   = 8'd0;
            sel_nxt   = 12'd0;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        sel_nxt   = 12'd0;
      end
    endcase
  end

  // State, counter, key mask, status pulses and row-3 history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      sel_mask <= 12'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      row3_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel_mask <= sel_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      row3_q   <= keypadr[3];
    end
  end

  assign pressed_clean = (state == PRESS) ? sel_mask : 12'd0;

`ifdef KEYPAD3C4R_PRESSER_BOUNCE_EN
  logic [7:0]  lfsr;
  logic [15:0] bcnt;
  logic        in_window;

  // Free-running x^8+x^6+x^5+x^4+1 LFSR supplying the bounce pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 8'hA5;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // Clocks spent in the current state; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  bcnt <= 16'd0;
    else if (state_nxt != state) bcnt <= 16'd0;
    else if (bcnt != 16'hFFFF)   bcnt <= bcnt + 16'd1;
  end

  assign in_window = (state == PRESS || state == RELEASE) &&
                     ({16'd0, bcnt} < BOUNCE_CYCLES);

  // Inside the bounce window the selected key chatters with the LFSR.
  always_comb begin
    pressed = pressed_clean;
    if (in_window) pressed = lfsr[0] ? sel_mask : 12'd0;
  end
`else
  logic unused_bounce;
  assign unused_bounce = (BOUNCE_CYCLES != 0);

  // Clean transitions: the mask follows the state directly.
  always_comb begin
    pressed = pressed_clean;
  end
`endif

  // Matrix return: OR of the column groups of every driven row, unregistered.
  always_comb begin
    keypadc = 3'b000;
    if (keypadr[0]) keypadc = keypadc | {pressed[3],  pressed[2], pressed[1]};
    if (keypadr[1]) keypadc = keypadc | {pressed[6],  pressed[5], pressed[4]};
    if (keypadr[2]) keypadc = keypadc | {pressed[9],  pressed[8], pressed[7]};
    if (keypadr[3]) keypadc = keypadc | {pressed[11], pressed[0], pressed[10]};
  end

  assign key_if.key_ready = (state == IDLE);
  assign key_if.busy      = (state == PRESS) || (state == RELEASE);
  assign key_if.done      = done_q;
  assign key_if.err       = err_q;
  assign key_if.pressed   = pressed;
  assign key_if.state_dbg = state;

endmodule

// File: tb/tb_keypad3c4r_presser.sv
// Testbench for keypad3c4r_presser: directed keystrokes, scoreboard of
// completion events, direct checks of the matrix return per row.
module tb_keypad3c4r_presser;

  localparam logic [7:0] HOLD = 8'd8;
  localparam logic [7:0] GAP  = 8'd8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keypadr;
  logic [2:0] keypadc;

  int checks = 0;
  int errors = 0;
  int scan_mode = 0;   // 0 rows off, 1 rotate, 2 frozen 1000, 3 frozen 0100
  logic acc_done;

  // Event record: {err, key mask, press ticks, gap ticks}
  logic [28:0] exp_q[$];

  keypad3c4r_presser_if key_if();

  keypad3c4r_presser #(
    .HOLD_SCANS(HOLD),
    .GAP_SCANS(GAP),
    .BOUNCE_CYCLES(12)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .keypadr(keypadr),
    .keypadc(keypadc),
    .key_if(key_if)
  );

  // Clock
  always #5 clk = ~clk;

  // Row driver emulating the scanner
  initial begin
    keypadr = 4'b0000;
    forever begin
      @(posedge clk);
      #1;
      case (scan_mode)
        1: keypadr = (keypadr == 4'b0001) ? 4'b0010 :
                     (keypadr == 4'b0010) ? 4'b0100 :
                     (keypadr == 4'b0100) ? 4'b1000 : 4'b0001;
        2: keypadr = 4'b1000;
        3: keypadr = 4'b0100;
        default: keypadr = 4'b0000;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference keypad layout: which row/column a key code sits in.
  function automatic logic [2:0] exp_cols(input logic [3:0] code, input logic [3:0] row);
    int r, c;
    case (code)
      4'd0:    begin r = 3; c = 1; end
      4'd10:   begin r = 3; c = 0; end
      4'd11:   begin r = 3; c = 2; end
      default: begin r = (int'(code) - 1) / 3; c = (int'(code) - 1) % 3; end
    endcase
    exp_cols = row[r] ? (3'b001 << c) : 3'b000;
  endfunction

  task automatic send_key(input logic [3:0] code);
    int n;
    logic [11:0] m;
    @(negedge clk);
    key_if.key_valid = 1'b1;
    key_if.key_code  = code;
    n = 0;
    while (!key_if.key_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!key_if.key_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: key_ready 0 required 1 for code %0d", code);
    end
    acc_done = key_if.done;
    m = 12'd1 << code;
    if (code >= 4'd12) exp_q.push_back({1'b1, 12'h000, 8'd0, 8'd0});
    else               exp_q.push_back({1'b0, m, HOLD, GAP});
    @(posedge clk);
    #1;
    key_if.key_valid = 1'b0;
    key_if.key_code  = 4'd0;
  endtask

  task automatic check_rows(input logic [3:0] code, input string name);
    repeat (4) begin
      @(negedge clk);
      check(name, {29'd0, keypadc}, {29'd0, exp_cols(code, keypadr)});
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!key_if.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, key_if.done}, 32'd1);
    @(negedge clk);
    check("done_width", {31'd0, key_if.done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    key_if.key_valid = 1'b0;
    key_if.key_code  = 4'd0;
    acc_done = 1'b0;

    fork
      // Monitor: builds an event record on every done/err pulse and
      // compares it with the oldest expected record.
      begin : monitor
        logic        prev3;
        logic        tk;
        int          pt, gt;
        logic [11:0] seen;
        logic [28:0] ev;
        prev3 = 1'b0; pt = 0; gt = 0; seen = 12'h0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            prev3 = 1'b0; pt = 0; gt = 0; seen = 12'h0;
          end else begin
            tk = keypadr[3] && !prev3;
            prev3 = keypadr[3];
            if (key_if.pressed != 12'h0) begin
              seen = key_if.pressed;
              if (tk) pt++;
            end else if (key_if.busy && tk) begin
              gt++;
            end
            if (key_if.done || key_if.err) begin
              ev = {key_if.err, (key_if.err ? 12'h000 : seen), 8'(pt), 8'(gt)};
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL event_unexpected: got %0h expected none at %0t", ev, $time);
              end else begin
                check("event", {3'd0, ev}, {3'd0, exp_q.pop_front()});
              end
              pt = 0; gt = 0; seen = 12'h0;
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_keypadc", {29'd0, keypadc}, 32'd0);
    check("rst_ready",   {31'd0, key_if.key_ready}, 32'd1);
    check("rst_busy",    {31'd0, key_if.busy}, 32'd0);
    check("rst_done",    {31'd0, key_if.done}, 32'd0);
    check("rst_err",     {31'd0, key_if.err}, 32'd0);
    check("rst_pressed", {20'd0, key_if.pressed}, 32'd0);
    check("rst_state",   {30'd0, key_if.state_dbg}, 32'd0);
    rst_n = 1'b1;
    scan_mode = 1;
    repeat (4) begin
      @(negedge clk);
      check("idle_keypadc", {29'd0, keypadc}, 32'd0);
    end

    // Key 5
    send_key(4'd5);
    @(negedge clk);
    check("pressed_5", {20'd0, key_if.pressed}, 32'h020);
    check("busy_5",    {31'd0, key_if.busy}, 32'd1);
    check_rows(4'd5, "cols_5");
    wait_done();

    // Hash, asterisk, zero
    send_key(4'd11);
    check_rows(4'd11, "cols_hash");
    wait_done();
    send_key(4'd10);
    check_rows(4'd10, "cols_ast");
    wait_done();
    send_key(4'd0);
    check_rows(4'd0, "cols_0");
    wait_done();

    // Invalid code
    send_key(4'd13);
    @(negedge clk);
    check("err_pulse",   {31'd0, key_if.err}, 32'd1);
    check("err_pressed", {20'd0, key_if.pressed}, 32'd0);
    check("err_ready",   {31'd0, key_if.key_ready}, 32'd1);
    check("err_busy",    {31'd0, key_if.busy}, 32'd0);
    @(negedge clk);
    check("err_width",   {31'd0, key_if.err}, 32'd0);
    repeat (20) @(negedge clk);

    // Frozen scanner during press
    send_key(4'd7);
    @(negedge clk);
    check("pressed_7", {20'd0, key_if.pressed}, 32'h080);
    scan_mode = 2;
    repeat (100) @(negedge clk);
    check("frozen_pressed", {20'd0, key_if.pressed}, 32'h080);
    check("frozen_busy",    {31'd0, key_if.busy}, 32'd1);
    scan_mode = 1;
    wait_done();

    // Back-to-back keystrokes
    send_key(4'd3);
    send_key(4'd8);
    check("b2b_accept_in_done", {31'd0, acc_done}, 32'd1);
    @(negedge clk);
    check("pressed_8", {20'd0, key_if.pressed}, 32'h100);
    wait_done();

    // Reset mid-press
    send_key(4'd9);
    scan_mode = 3;
    repeat (3) @(negedge clk);
    check("pre_rst_cols", {29'd0, keypadc}, 32'd4);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_cols",    {29'd0, keypadc}, 32'd0);
    check("async_pressed", {20'd0, key_if.pressed}, 32'd0);
    check("async_busy",    {31'd0, key_if.busy}, 32'd0);
    check("async_ready",   {31'd0, key_if.key_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    scan_mode = 1;
    repeat (2) @(negedge clk);
    send_key(4'd4);
    check_rows(4'd4, "cols_4");
    wait_done();

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
